// File: rtl/led_blink_arbiter_if.sv
// ---------------------------------------------------------------------------
// led_blink_arbiter_if
// Groups the request/response signals of the LED blink arbiter.
//   req   [3:0]  per-requester blink request, level-sensitive
//   cnt   [15:0] blink counts, nibble i for requester i (0 encodes 16)
//   led          shared LED drive, 1 = lit
//   grant [3:0]  one-hot owner of the LED, zero when idle
//   busy         high while a burst is in progress
//   done  [3:0]  one-cycle completion pulse for the owning requester
// master: the side that issues requests; slave: the arbiter itself.
// ---------------------------------------------------------------------------
interface led_blink_arbiter_if;
   logic [3:0]  req;
   logic [15:0] cnt;
   logic        led;
   logic [3:0]  grant;
   logic        busy;
   logic [3:0]  done;

   modport master (output req, cnt, input led, grant, busy, done);
   modport slave  (input req, cnt, output led, grant, busy, done);
endinterface

// File: rtl/led_blink_arbiter.sv
// ---------------------------------------------------------------------------
// led_blink_arbiter
// Shares one LED between four requesters. A granted requester gets a burst
// of N blinks (N from its cnt nibble, 0 meaning 16), each blink being one
// lit and one dark half-period of TICK_CYCLES clocks, followed by GAP_TICKS
// dark half-periods. Requesters are served round-robin.
// Ports:
//   clk    system clock, all state on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    led_blink_arbiter_if.slave (req, cnt in; led, grant, busy, done out)
// ---------------------------------------------------------------------------
module led_blink_arbiter #(
   parameter logic [31:0] TICK_CYCLES = 32'd25_000_000,
   parameter logic [7:0]  GAP_TICKS   = 8'd2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   led_blink_arbiter_if.slave         bus
);

   localparam logic [31:0] TICK_LAST = TICK_CYCLES - 32'd1;
   localparam logic [7:0]  GAP_LAST  = GAP_TICKS - 8'd1;

   typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;

   state_t      state, state_next;
   logic [31:0] tick_cnt, tick_next;
   logic [7:0]  gap_cnt, gap_next;
   logic [4:0]  remaining, rem_next;
   logic [1:0]  last_grant, last_next;
   logic [3:0]  grant_q, grant_next;
   logic        led_q;
   logic [3:0]  done_c;
   logic        tick;

   logic        pick_valid;
   logic [1:0]  pick_idx;
   logic [1:0]  cand;
   logic [3:0]  nibble;

   assign tick   = (tick_cnt == TICK_LAST);
   assign nibble = bus.cnt[{pick_idx, 2'b00} +: 4];

   // Round-robin search starting just after the last owner. Candidates are
   // visited from lowest to highest priority so the nearest asserted
   // requester overwrites the earlier ones; offset 0 (the last owner itself)
   // comes last in priority, so a repeat requester loses to anyone else.
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = 2'd0;
      cand       = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         cand = last_grant + 2'(k + 1);
         if (bus.req[cand]) begin
            pick_valid = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   // Next-state logic. The half-period counter runs only outside IDLE and
   // wraps on each tick; the gap counter counts ticks spent in GAP. done is
   // raised during the final GAP cycle, while grant still names the owner.
   always_comb begin
      state_next = state;
      tick_next  = tick_cnt;
      gap_next   = gap_cnt;
      rem_next   = remaining;
      last_next  = last_grant;
      grant_next = grant_q;
      done_c     = 4'b0000;
      unique case (state)
         IDLE: begin
            tick_next  = 32'd0;
            gap_next   = 8'd0;
            grant_next = 4'b0000;
            if (pick_valid) begin
               state_next = ON;
               grant_next = 4'b0001 << pick_idx;
               last_next  = pick_idx;
               rem_next   = (nibble == 4'd0) ? 5'd16 : {1'b0, nibble};
            end
         end
         ON: begin
            tick_next = tick ? 32'd0 : tick_cnt + 32'd1;
            if (tick) state_next = OFF;
         end
         OFF: begin
            tick_next = tick ? 32'd0 : tick_cnt + 32'd1;
            if (tick) begin
               rem_next   = remaining - 5'd1;
               state_next = (remaining == 5'd1) ? GAP : ON;
            end
         end
         GAP: begin
            tick_next = tick ? 32'd0 : tick_cnt + 32'd1;
            if (tick) begin
               if (gap_cnt == GAP_LAST) begin
                  state_next = IDLE;
                  gap_next   = 8'd0;
                  grant_next = 4'b0000;
                  done_c     = grant_q;
               end else begin
                  gap_next = gap_cnt + 8'd1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State and output registers. led is computed from the next state so the
   // registered LED is lit exactly during ON cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         tick_cnt   <= 32'd0;
         gap_cnt    <= 8'd0;
         remaining  <= 5'd0;
         last_grant <= 2'd3;
         grant_q    <= 4'b0000;
         led_q      <= 1'b0;
      end else begin
         state      <= state_next;
         tick_cnt   <= tick_next;
         gap_cnt    <= gap_next;
         remaining  <= rem_next;
         last_grant <= last_next;
         grant_q    <= grant_next;
         led_q      <= (state_next == ON);
      end
   end

   assign bus.led   = led_q;
   assign bus.grant = grant_q;
   assign bus.busy  = (state != IDLE);
   assign bus.done  = done_c;

endmodule
